// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU opcode sweep sequencer.
// Holds the FSM encoding, the stored result format and opcode sizing.
package alu_op_sequencer_pkg;

    localparam int OP_W     = 4;
    localparam int OP_COUNT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    // Stored result: {carry, y}
    typedef logic [4:0] result_entry_t;

    localparam result_entry_t ENTRY_ZERO = 5'd0;

    function automatic result_entry_t make_entry(input logic carry, input logic [OP_W-1:0] y);
        return {carry, y};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ALU-side bus: operands/opcode toward the ALU, result/carry back.
interface alu_op_sequencer_if;
    import alu_op_sequencer_pkg::*;

    logic [OP_W-1:0] alu_a;
    logic [OP_W-1:0] alu_b;
    logic [OP_W-1:0] alu_op_sel;
    logic [OP_W-1:0] alu_y;
    logic            alu_carry;

    modport master (
        output alu_a,
        output alu_b,
        output alu_op_sel,
        input  alu_y,
        input  alu_carry
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op_sel,
        output alu_y,
        output alu_carry
    );

endinterface

// File: rtl/alu_op_sequencer_result_buf.sv
// 16x5 result buffer: synchronous write, registered read, async clear.
// A read of the entry being written in the same cycle returns the old data.
module alu_result_buf
    import alu_op_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [OP_W-1:0] wr_addr,
    input  result_entry_t   wr_data,
    input  logic [OP_W-1:0] rd_addr,
    output result_entry_t   rd_data
);

    result_entry_t mem_r [OP_COUNT];

    // Storage array: cleared on reset, written on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OP_COUNT; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= ENTRY_ZERO;
        end else begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sweeps opcodes 0..LAST_OP through an external ALU with fixed operands,
// letting each settle SETTLE_CYCLES cycles before storing {carry, y}.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 32'd2,
    parameter int unsigned LAST_OP       = 32'd15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [OP_W-1:0]     a_in,
    input  logic [OP_W-1:0]     b_in,
    alu_op_sequencer_if.master  alu,
    output logic                busy,
    output logic                done,
    input  logic [OP_W-1:0]     rd_addr,
    output logic [4:0]          rd_data
);

    localparam logic [OP_W-1:0] LAST_OP_C       = OP_W'(LAST_OP);
    localparam logic [3:0]      SETTLE_RELOAD_C = 4'(SETTLE_CYCLES - 32'd1);

    seq_state_t      state_r;
    seq_state_t      state_nxt_s;

    logic [OP_W-1:0] alu_a_r;
    logic [OP_W-1:0] alu_b_r;
    logic [OP_W-1:0] op_r;
    logic [3:0]      cnt_r;
    logic            busy_r;
    logic            done_r;

    logic [OP_W-1:0] alu_a_nxt_s;
    logic [OP_W-1:0] alu_b_nxt_s;
    logic [OP_W-1:0] op_nxt_s;
    logic [3:0]      cnt_nxt_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic            wr_en_s;
    result_entry_t   wr_data_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks both start and capture
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_nxt_s = ST_SETTLE;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (abort)                state_nxt_s = ST_IDLE;
                else if (cnt_r == 4'd0)   state_nxt_s = ST_CAPTURE;
                else                      state_nxt_s = ST_SETTLE;
            end
            ST_CAPTURE: begin
                if (abort)                  state_nxt_s = ST_IDLE;
                else if (op_r == LAST_OP_C) state_nxt_s = ST_DONE;
                else                        state_nxt_s = ST_SETTLE;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values; busy and done follow the upcoming state
    always_comb begin
        alu_a_nxt_s = alu_a_r;
        alu_b_nxt_s = alu_b_r;
        op_nxt_s    = op_r;
        cnt_nxt_s   = cnt_r;
        wr_en_s     = 1'b0;
        wr_data_s   = make_entry(alu.alu_carry, alu.alu_y);
        busy_nxt_s  = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_CAPTURE);
        done_nxt_s  = (state_nxt_s == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (state_nxt_s == ST_SETTLE) begin
                    alu_a_nxt_s = a_in;
                    alu_b_nxt_s = b_in;
                    op_nxt_s    = {OP_W{1'b0}};
                    cnt_nxt_s   = SETTLE_RELOAD_C;
                end else begin
                    op_nxt_s    = op_r;
                end
            end
            ST_SETTLE: begin
                if (!abort && (cnt_r != 4'd0)) cnt_nxt_s = cnt_r - 4'd1;
                else                           cnt_nxt_s = cnt_r;
            end
            ST_CAPTURE: begin
                if (!abort) begin
                    wr_en_s = 1'b1;
                    // Opcode stops at LAST_OP so it never wraps
                    if (op_r != LAST_OP_C) begin
                        op_nxt_s  = op_r + 4'd1;
                        cnt_nxt_s = SETTLE_RELOAD_C;
                    end else begin
                        op_nxt_s  = op_r;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_DONE: begin
                op_nxt_s = op_r;
            end
            default: begin
                op_nxt_s = op_r;
            end
        endcase
    end

    // Registered datapath and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r <= 4'd0;
            alu_b_r <= 4'd0;
            op_r    <= 4'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            alu_a_r <= alu_a_nxt_s;
            alu_b_r <= alu_b_nxt_s;
            op_r    <= op_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign alu.alu_a      = alu_a_r;
    assign alu.alu_b      = alu_b_r;
    assign alu.alu_op_sel = op_r;
    assign busy           = busy_r;
    assign done           = done_r;

    alu_result_buf u_result_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (op_r),
        .wr_data (wr_data_s),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an ALU loopback (y=op, carry=op[0]).
// dut1 uses default parameters, dut2 uses SETTLE_CYCLES=1, LAST_OP=3.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [3:0] a_in1 = 4'd0, b_in1 = 4'd0, rd_addr1 = 4'd0;
    logic       busy1, done1;
    logic [4:0] rd_data1;
    logic       start2 = 1'b0, abort2 = 1'b0;
    logic [3:0] a_in2 = 4'd0, b_in2 = 4'd0, rd_addr2 = 4'd0;
    logic       busy2, done2;
    logic [4:0] rd_data2;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_op_sequencer_if bus1();
    alu_op_sequencer_if bus2();

    assign bus1.alu_y     = bus1.alu_op_sel;
    assign bus1.alu_carry = bus1.alu_op_sel[0];
    assign bus2.alu_y     = bus2.alu_op_sel;
    assign bus2.alu_carry = bus2.alu_op_sel[0];

    alu_op_sequencer dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a_in(a_in1), .b_in(b_in1), .alu(bus1), .busy(busy1), .done(done1),
        .rd_addr(rd_addr1), .rd_data(rd_data1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(32'd1), .LAST_OP(32'd3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .a_in(a_in2), .b_in(b_in2), .alu(bus2), .busy(busy2), .done(done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int entry_of(input int op);
        return ((op % 2) << 4) | op;
    endfunction

    // Runs a full default sweep on dut1 (start already accepted, buffer clear),
    // reading back through rd_addr each cycle with a hand-derived timing model:
    // entry i is written on edge 3*(i+1) after accept.
    task automatic run_sweep(input string tag, input int a, input int b);
        int  done_at;
        int  idx;
        int  exp_v;
        bit  ab_ok;
        done_at = -1;
        ab_ok   = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            idx      = (k < 3) ? 15 : ((k / 3) - 1) % 16;
            rd_addr1 = 4'(idx);
            tick();
            if (k == 1) check_vec({tag, "_busy"}, int'(busy1), 1);
            if (int'(bus1.alu_a) != a || int'(bus1.alu_b) != b) ab_ok = 1'b0;
            if (k <= 48) begin
                exp_v = ((idx + 1) * 3 < k) ? entry_of(idx) : 0;
                check_vec({tag, "_rd"}, int'(rd_data1), exp_v);
            end
            if (done1 === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check_vec({tag, "_done_cycle"}, done_at, 48);
        check_vec({tag, "_ab_hold"}, int'(ab_ok), 1);
        check_vec({tag, "_busy_in_done"}, int'(busy1), 0);
        tick();
        check_vec({tag, "_done_pulse"}, int'(done1), 0);
        check_vec({tag, "_op_hold"}, int'(bus1.alu_op_sel), 15);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            tick();
            check_vec({tag, "_buf"}, int'(rd_data1), entry_of(i));
        end
    endtask

    initial begin
        int  done_at;
        bit  saw_done;

        // Reset state
        #2;
        check_vec("rst_busy", int'(busy1), 0);
        check_vec("rst_done", int'(done1), 0);
        check_vec("rst_alu_a", int'(bus1.alu_a), 0);
        check_vec("rst_op", int'(bus1.alu_op_sel), 0);
        check_vec("rst_rd", int'(rd_data1), 0);
        tick();
        rst_n = 1'b1;

        // Full default sweep
        a_in1 = 4'd5; b_in1 = 4'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_sweep("sweepA", 5, 3);

        // Short sweep: SETTLE_CYCLES=1, LAST_OP=3
        a_in2 = 4'd5; b_in2 = 4'd3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done2 === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check_vec("short_done_cycle", done_at, 8);
        check_vec("short_op_last", int'(bus2.alu_op_sel), 3);
        for (int i = 0; i < 16; i++) begin
            rd_addr2 = 4'(i);
            tick();
            check_vec("short_buf", int'(rd_data2), (i <= 3) ? entry_of(i) : 0);
        end

        // Reset mid-sweep at op 9, then restart on the first edge
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 28; k++) tick();
        check_vec("pre_rst_op", int'(bus1.alu_op_sel), 9);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_busy", int'(busy1), 0);
        check_vec("mid_rst_done", int'(done1), 0);
        check_vec("mid_rst_alu_a", int'(bus1.alu_a), 0);
        check_vec("mid_rst_alu_b", int'(bus1.alu_b), 0);
        check_vec("mid_rst_op", int'(bus1.alu_op_sel), 0);
        check_vec("mid_rst_rd", int'(rd_data1), 0);
        #1;
        rst_n  = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_sweep("sweepR", 5, 3);

        // Abort in the capture cycle of op 6
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        check_vec("pre_abort_op", int'(bus1.alu_op_sel), 6);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check_vec("abort_busy", int'(busy1), 0);
        check_vec("abort_op_hold", int'(bus1.alu_op_sel), 6);
        saw_done = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done1 === 1'b1) saw_done = 1'b1;
        end
        check_vec("abort_no_done", int'(saw_done), 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 4'(i);
            tick();
            check_vec("abort_buf", int'(rd_data1), (i <= 5) ? entry_of(i) : 0);
        end

        // start+abort together in IDLE is ignored
        a_in1 = 4'd9; start1 = 1'b1; abort1 = 1'b1;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        check_vec("sa_busy", int'(busy1), 0);
        check_vec("sa_op", int'(bus1.alu_op_sel), 6);
        check_vec("sa_alu_a", int'(bus1.alu_a), 5);
        tick();
        check_vec("sa_no_queue", int'(busy1), 0);

        // start re-pulsed while busy is ignored
        a_in1 = 4'd7; b_in1 = 4'd2; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k == 10) begin
                start1 = 1'b1; a_in1 = 4'd1; b_in1 = 4'd1;
            end else begin
                start1 = 1'b0;
            end
            tick();
            if (k == 10) begin
                check_vec("rep_busy", int'(busy1), 1);
                check_vec("rep_op", int'(bus1.alu_op_sel), 3);
                check_vec("rep_alu_a", int'(bus1.alu_a), 7);
                check_vec("rep_alu_b", int'(bus1.alu_b), 2);
            end
            if (done1 === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check_vec("rep_done_cycle", done_at, 48);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles each opcode is held on the ALU before capture; legal range 1..15.
REQ-002 SHALL have parameter LAST_OP, default 15: final opcode of a sweep; legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  terminates the running sweep.
REQ-007 SHALL have port a_in  input  4  operand A, latched on accepted start.
REQ-008 SHALL have port b_in  input  4  operand B, latched on accepted start.
REQ-009 SHALL have port alu_a, alu_b  output  4 each  registered operands driven to the ALU.
REQ-010 SHALL have port alu_op_sel  output  4  registered opcode driven to the ALU.
REQ-011 SHALL have port alu_y  input  4  ALU result.
REQ-012 SHALL have port alu_carry  input  1  ALU carry.
REQ-013 SHALL have port busy  output  1  high while a sweep runs.
REQ-014 SHALL have port done  output  1  one-cycle pulse at normal sweep completion.
REQ-015 SHALL have port rd_addr  input  4  result-buffer read index.
REQ-016 SHALL have port rd_data  output  5  {carry, y} stored at rd_addr, registered.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DONE.
REQ-018 IDLE: start=1 and abort=0 -> latch a_in/b_in onto alu_a/alu_b, alu_op_sel=0, settle counter=SETTLE_CYCLES-1, go SETTLE.
REQ-019 SETTLE: counter decrements each cycle; go CAPTURE on the cycle the counter is 0.
REQ-020 CAPTURE: write {alu_carry, alu_y} to buffer[alu_op_sel]; if alu_op_sel==LAST_OP go DONE, else alu_op_sel+1, reload counter, go SETTLE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 Per-opcode cost SHALL be SETTLE_CYCLES+1 cycles; done SHALL rise (LAST_OP+1)*(SETTLE_CYCLES+1) cycles after the start-accept edge.
REQ-023 busy SHALL be 1 in SETTLE and CAPTURE, 0 in IDLE and DONE.
REQ-024 start while not IDLE SHALL be ignored, with no queuing.
REQ-025 abort=1 in SETTLE or CAPTURE SHALL go IDLE next edge, with no buffer write that cycle and no done; abort has priority over CAPTURE. Already-written entries are kept.
REQ-026 start and abort both high in IDLE: abort wins; the sweep is not started.
REQ-027 alu_a/alu_b/alu_op_sel SHALL hold their last values in IDLE and DONE.
REQ-028 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is sampled, in any state; reads of an index written the same cycle return the old value.
REQ-029 The opcode counter SHALL not wrap past LAST_OP; entries above LAST_OP are never written.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, alu_a=alu_b=alu_op_sel=0, counter=0, all 16 buffer entries=0, rd_data=0.
REQ-031 Reset mid-sweep SHALL abandon the sweep with no done pulse; start is honoured on the first edge after rst_n deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the 5-bit result-entry type, and the opcode-count constant (16).
REQ-033 The 16x5 result buffer SHALL be one sub-module, alu_result_buf (sync write port, registered read port, async clear).

Verification
REQ-034 Bench ALU loopback model drives alu_y=alu_op_sel and alu_carry=alu_op_sel[0]. With a_in=5, b_in=3, start pulse, defaults -> done 48 cycles after accept; buffer[i]={i[0],i} for i=0..15; alu_a=5, alu_b=3 throughout.
REQ-035 SETTLE_CYCLES=1, LAST_OP=3 -> done after 8 cycles; buffer[0..3] written; buffer[4..15] remain 0.
REQ-036 Abort asserted in the CAPTURE cycle of op 6 -> IDLE next edge, no done, buffer[0..5] valid, buffer[6]=0.
REQ-037 start re-pulsed while busy, and start+abort together in IDLE -> no effect on the sweep, alu_op_sel, or busy.
REQ-038 rst_n low mid-sweep at op 9 -> all outputs 0 immediately (no clock edge needed), buffer cleared, a new start runs a full sweep.
REQ-039 rd_addr swept 0..15 during an active sweep -> rd_data tracks the buffer with 1-cycle latency, showing old data on the same-cycle-write index.
